// File: rtl/eq_seq_pkg.sv
// eq_seq_pkg
// Shared constants, state type and saturation helper for the EQ scale sequencer.
// Optional feature macro used by the design files: EQ_SEQ_SAT_EN
//   defined   -> band terms and channel sums saturate to signed 16 bit
//   undefined -> band terms and channel sums wrap modulo 2^16
package eq_seq_pkg;

    localparam int SMPL_W     = 16;
    localparam int POT_W      = 12;
    localparam int NBANDS     = 5;
    localparam int LATENCY    = 20;
    localparam int GAIN_SHIFT = 11;
    localparam int VOL_SHIFT  = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQR   = 3'd1,
        BAND  = 3'd2,
        VOL   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Clamp a wide signed value into the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
        if (x > 34'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -34'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/eq_scale_sequencer_if.sv
// eq_scale_sequencer_if
// Request/result bundle between the FIR band outputs and the codec path.
//   strt                  one-cycle sample request
//   band_lft / band_rght  5 x signed 16b band samples, band i at [16i+15:16i]
//   pots                  5 x unsigned 12b band pots, same packing
//   VOLUME                unsigned 12b volume
//   clr_ovr               clears the sticky overrun flag
//   busy, vld_out         sequencer status / one-cycle result strobe
//   aud_out_lft/rght      16b signed results (two's complement bits)
//   ovr                   sticky overrun flag
// master = requester side, slave = sequencer side.
interface eq_scale_sequencer_if;
    import eq_seq_pkg::*;

    logic                       strt;
    logic [SMPL_W*NBANDS-1:0]   band_lft;
    logic [SMPL_W*NBANDS-1:0]   band_rght;
    logic [POT_W*NBANDS-1:0]    pots;
    logic [POT_W-1:0]           VOLUME;
    logic                       clr_ovr;
    logic                       busy;
    logic                       vld_out;
    logic [SMPL_W-1:0]          aud_out_lft;
    logic [SMPL_W-1:0]          aud_out_rght;
    logic                       ovr;

    modport master (
        output strt, band_lft, band_rght, pots, VOLUME, clr_ovr,
        input  busy, vld_out, aud_out_lft, aud_out_rght, ovr
    );

    modport slave (
        input  strt, band_lft, band_rght, pots, VOLUME, clr_ovr,
        output busy, vld_out, aud_out_lft, aud_out_rght, ovr
    );

endinterface

// File: rtl/eq_mac.sv
// eq_mac
// The single shared 17x17 signed multiplier with a registered product.
// Also derives the band term (product >>> 11) from the registered product,
// saturated when EQ_SEQ_SAT_EN is defined, wrapped to 16 bits otherwise.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_a, i_b    signed operands issued this cycle
//   o_prod      registered full product (valid the cycle after issue)
//   o_term      band term taken from o_prod
module eq_mac
    import eq_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [16:0]  i_a,
    input  logic signed [16:0]  i_b,
    output logic signed [33:0]  o_prod,
    output logic signed [15:0]  o_term
);

    logic signed [33:0] w_prod;
    logic signed [33:0] r_prod;

    assign w_prod = i_a * i_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
        end else begin
            r_prod <= w_prod;
        end
    end

    assign o_prod = r_prod;

`ifdef EQ_SEQ_SAT_EN
    logic signed [33:0] w_shift;
    assign w_shift = r_prod >>> GAIN_SHIFT;
    assign o_term  = sat16(w_shift);
`else
    // Legacy truncation: keep product bits [26:11] only.
    assign o_term  = r_prod[GAIN_SHIFT +: 16];
`endif

endmodule

// File: rtl/eq_scale_sequencer.sv
// eq_scale_sequencer
// Performs all post-FIR EQ math for one stereo sample on one shared multiplier:
// 5 pot squarings, 10 band gain scalings with per-channel accumulation, and
// 2 volume scalings. Result appears exactly LATENCY cycles after strt.
// Optional feature macro: EQ_SEQ_SAT_EN (saturating band terms and sums).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         eq_scale_sequencer_if.slave (request inputs, results, status)
module eq_scale_sequencer
    import eq_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    eq_scale_sequencer_if.slave     bus
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_SQR   = SQR;
    localparam logic [2:0] ST_BAND  = BAND;
    localparam logic [2:0] ST_VOL   = VOL;
    localparam logic [2:0] ST_DRAIN = DRAIN;

    // r_cnt counts cycles since the accepting edge; the whole schedule keys off it.
    localparam logic [4:0] CNT_SQR_END  = 5'd4;
    localparam logic [4:0] CNT_BAND_END = 5'd14;
    localparam logic [4:0] CNT_VOL_END  = 5'd16;
    localparam logic [4:0] CNT_DONE     = 5'(LATENCY);

    logic [2:0]                 r_state;
    logic [4:0]                 r_cnt;
    logic [POT_W-1:0]           r_pot       [NBANDS];
    logic signed [SMPL_W-1:0]   r_band_lft  [NBANDS];
    logic signed [SMPL_W-1:0]   r_band_rght [NBANDS];
    logic [POT_W-1:0]           r_vol;
    logic [POT_W-1:0]           r_gain      [NBANDS];
    logic signed [18:0]         r_sum_lft;
    logic signed [18:0]         r_sum_rght;
    logic [SMPL_W-1:0]          r_hold_lft;
    logic [SMPL_W-1:0]          r_hold_rght;
    logic                       r_vld;
    logic [SMPL_W-1:0]          r_out_lft;
    logic [SMPL_W-1:0]          r_out_rght;
    logic                       r_ovr;

    logic                       w_busy;
    logic                       w_accept;
    logic signed [16:0]         w_a;
    logic signed [16:0]         w_b;
    logic signed [33:0]         w_prod;
    logic signed [15:0]         w_term;
    logic [3:0]                 w_bidx;
    logic [2:0]                 w_gidx;
    logic signed [15:0]         w_band;
    logic signed [15:0]         w_sum16_lft;
    logic signed [15:0]         w_sum16_rght;
    logic signed [15:0]         w_vsel;
    logic                       w_unused_prod;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_accept = bus.strt && !w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= ST_SQR;
            r_cnt   <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 5'd1;
            case (r_state)
                ST_SQR:   if (r_cnt == CNT_SQR_END)  r_state <= ST_BAND;
                ST_BAND:  if (r_cnt == CNT_BAND_END) r_state <= ST_VOL;
                ST_VOL:   if (r_cnt == CNT_VOL_END)  r_state <= ST_DRAIN;
                ST_DRAIN: if (r_cnt == CNT_DONE) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Every input is captured on the accepting edge so the request side may move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBANDS; i++) begin
                r_pot[i]       <= '0;
                r_band_lft[i]  <= '0;
                r_band_rght[i] <= '0;
            end
            r_vol <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NBANDS; i++) begin
                r_pot[i]       <= bus.pots[POT_W*i +: POT_W];
                r_band_lft[i]  <= bus.band_lft[SMPL_W*i +: SMPL_W];
                r_band_rght[i] <= bus.band_rght[SMPL_W*i +: SMPL_W];
            end
            r_vol <= bus.VOLUME;
        end
    end

    // BAND issue order is lft0..4 then rght0..4; both halves reuse gains 0..4.
    assign w_bidx = 4'(r_cnt - 5'd5);
    assign w_gidx = (w_bidx >= 4'd5) ? 3'(w_bidx - 4'd5) : w_bidx[2:0];
    assign w_band = (w_bidx < 4'd5) ? r_band_lft[w_gidx] : r_band_rght[w_gidx];

`ifdef EQ_SEQ_SAT_EN
    assign w_sum16_lft  = sat16({{15{r_sum_lft[18]}}, r_sum_lft});
    assign w_sum16_rght = sat16({{15{r_sum_rght[18]}}, r_sum_rght});
`else
    logic w_unused_sum;
    assign w_sum16_lft  = r_sum_lft[15:0];
    assign w_sum16_rght = r_sum_rght[15:0];
    assign w_unused_sum = ^{r_sum_lft[18:16], r_sum_rght[18:16]};
`endif

    assign w_vsel = (r_cnt == CNT_BAND_END + 5'd1) ? w_sum16_lft : w_sum16_rght;

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_state)
            ST_SQR: begin
                w_a = {5'b0, r_pot[r_cnt[2:0]]};
                w_b = {5'b0, r_pot[r_cnt[2:0]]};
            end
            ST_BAND: begin
                w_a = {w_band[15], w_band};
                w_b = {5'b0, r_gain[w_gidx]};
            end
            ST_VOL: begin
                w_a = {w_vsel[15], w_vsel};
                w_b = {5'b0, r_vol};
            end
            default: begin
                w_a = '0;
                w_b = '0;
            end
        endcase
    end

    eq_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_prod (w_prod),
        .o_term (w_term)
    );

    assign w_unused_prod = ^{w_prod[33:28], w_prod[11:0]};

    // Products land one cycle after issue, so each capture window is the issue window shifted by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBANDS; i++) begin
                r_gain[i] <= '0;
            end
            r_sum_lft   <= '0;
            r_sum_rght  <= '0;
            r_hold_lft  <= '0;
            r_hold_rght <= '0;
        end else if (w_accept) begin
            r_sum_lft  <= '0;
            r_sum_rght <= '0;
        end else if (w_busy) begin
            if (r_cnt >= 5'd1 && r_cnt <= 5'd5) begin
                r_gain[3'(r_cnt - 5'd1)] <= w_prod[POT_W +: POT_W];
            end
            if (r_cnt >= 5'd6 && r_cnt <= 5'd10) begin
                r_sum_lft <= r_sum_lft + {{3{w_term[15]}}, w_term};
            end
            if (r_cnt >= 5'd11 && r_cnt <= 5'd15) begin
                r_sum_rght <= r_sum_rght + {{3{w_term[15]}}, w_term};
            end
            if (r_cnt == CNT_VOL_END) begin
                r_hold_lft <= w_prod[VOL_SHIFT +: SMPL_W];
            end
            if (r_cnt == CNT_VOL_END + 5'd1) begin
                r_hold_rght <= w_prod[VOL_SHIFT +: SMPL_W];
            end
        end
    end

    // Results are published together, one cycle before the FSM returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld      <= 1'b0;
            r_out_lft  <= '0;
            r_out_rght <= '0;
            r_ovr      <= 1'b0;
        end else begin
            r_vld <= w_busy && (r_cnt == CNT_DONE - 5'd1);
            if (w_busy && (r_cnt == CNT_DONE - 5'd1)) begin
                r_out_lft  <= r_hold_lft;
                r_out_rght <= r_hold_rght;
            end
            if (bus.clr_ovr) begin
                r_ovr <= 1'b0;
            end else if (bus.strt && w_busy) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.vld_out      = r_vld;
    assign bus.aud_out_lft  = r_out_lft;
    assign bus.aud_out_rght = r_out_rght;
    assign bus.ovr          = r_ovr;

endmodule

// File: tb/tb_eq_scale_sequencer.sv
// tb_eq_scale_sequencer
// Self-checking bench for eq_scale_sequencer: directed cases plus randomized
// samples compared against an arithmetic reference model of the EQ math.
// Honours EQ_SEQ_SAT_EN the same way the design does.
module tb_eq_scale_sequencer;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    eq_scale_sequencer_if bus();

    eq_scale_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Straight arithmetic of the EQ rules: gain, floored term, sum, volume.
    function automatic logic [15:0] modelChannel(input logic [79:0] bands, input logic [59:0] potsIn,
                                                 input logic [11:0] vol);
        longint sum;
        longint p;
        longint g;
        longint b;
        longint term;
        longint outv;
        sum = 0;
        for (int i = 0; i < 5; i++) begin
            p    = longint'(potsIn[12*i +: 12]);
            g    = (p * p) / 4096;
            b    = longint'($signed(bands[16*i +: 16]));
            term = (b * g) >>> 11;
`ifdef EQ_SEQ_SAT_EN
            if (term > 32767)  term = 32767;
            if (term < -32768) term = -32768;
`else
            term = longint'($signed(term[15:0]));
`endif
            sum += term;
        end
`ifdef EQ_SEQ_SAT_EN
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
`else
        sum = longint'($signed(sum[15:0]));
`endif
        outv = (sum * longint'(vol)) >>> 12;
        return outv[15:0];
    endfunction

    task automatic applyStimulus(input logic [79:0] bl, input logic [79:0] br, input logic [59:0] p,
                                 input logic [11:0] v);
        bus.band_lft  = bl;
        bus.band_rght = br;
        bus.pots      = p;
        bus.VOLUME    = v;
        bus.strt      = 1'b1;
        @(posedge clk);
        #1;
        bus.strt      = 1'b0;
    endtask

    // Waits (bounded) for vld_out, captures outputs, then steps one more edge so the FSM is idle.
    task automatic waitForValid(output int lat, output logic [15:0] gotL, output logic [15:0] gotR);
        lat  = -1;
        gotL = 'x;
        gotR = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.vld_out === 1'b1) begin
                lat  = n;
                gotL = bus.aud_out_lft;
                gotR = bus.aud_out_rght;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic countValid(input int cycles, output int seen);
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (bus.vld_out === 1'b1) seen++;
        end
    endtask

    function automatic logic [79:0] randBands();
        logic [95:0] tmp;
        tmp = {$urandom(), $urandom(), $urandom()};
        return tmp[79:0];
    endfunction

    function automatic logic [59:0] randPots();
        logic [63:0] tmp;
        tmp = {$urandom(), $urandom()};
        return tmp[59:0];
    endfunction

    initial begin
        logic [79:0] bl;
        logic [79:0] br;
        logic [79:0] bl2;
        logic [79:0] br2;
        logic [59:0] pt;
        logic [59:0] pt2;
        logic [11:0] vl;
        logic [15:0] expL;
        logic [15:0] expR;
        logic [15:0] gotL;
        logic [15:0] gotR;
        int          lat;
        int          seen;

        checkCount    = 0;
        errorCount    = 0;
        rst_n         = 1'b0;
        bus.strt      = 1'b0;
        bus.band_lft  = '0;
        bus.band_rght = '0;
        bus.pots      = '0;
        bus.VOLUME    = '0;
        bus.clr_ovr   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstVld",  32'(bus.vld_out), 32'd0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstLft",  32'(bus.aud_out_lft), 32'd0);
        checkOutput("rstRght", 32'(bus.aud_out_rght), 32'd0);
        checkOutput("rstOvr",  32'(bus.ovr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single band");
        bl = '0;
        bl[15:0] = 16'h1000;
        pt = {12'h0, 12'h0, 12'h0, 12'h0, 12'hFFF};
        applyStimulus(bl, '0, pt, 12'hFFF);
        checkOutput("busyHigh", 32'(bus.busy), 32'd1);
        waitForValid(lat, gotL, gotR);
        checkOutput("singleLat",  lat, 32'd20);
        checkOutput("singleLft",  32'(gotL), 32'd8186);
        checkOutput("singleRght", 32'(gotR), 32'd0);
        checkOutput("busyLow", 32'(bus.busy), 32'd0);

        $display("[TB] saturation corners");
        bl = {5{16'h7FFF}};
        pt = {5{12'hFFF}};
        applyStimulus(bl, '0, pt, 12'hFFF);
        waitForValid(lat, gotL, gotR);
        checkOutput("posSatLft", 32'(gotL), 32'(modelChannel(bl, pt, 12'hFFF)));
`ifdef EQ_SEQ_SAT_EN
        checkOutput("posSatConst", 32'(gotL), 32'h7FF7);
`endif
        br = {5{16'h8000}};
        applyStimulus('0, br, pt, 12'hFFF);
        waitForValid(lat, gotL, gotR);
        checkOutput("negSatRght", 32'(gotR), 32'(modelChannel(br, pt, 12'hFFF)));
`ifdef EQ_SEQ_SAT_EN
        checkOutput("negSatConst", 32'(gotR), 32'h8008);
`endif

        $display("[TB] randomized samples");
        for (int k = 0; k < 12; k++) begin
            bl = randBands();
            br = randBands();
            pt = (k % 4 == 0) ? {5{12'hFFF}} : randPots();
            vl = (k % 5 == 0) ? 12'hFFF : 12'($urandom());
            expL = modelChannel(bl, pt, vl);
            expR = modelChannel(br, pt, vl);
            applyStimulus(bl, br, pt, vl);
            waitForValid(lat, gotL, gotR);
            checkOutput("randLat",  lat, 32'd20);
            checkOutput("randLft",  32'(gotL), 32'(expL));
            checkOutput("randRght", 32'(gotR), 32'(expR));
        end
        checkOutput("ovrClean", 32'(bus.ovr), 32'd0);

        $display("[TB] overrun");
        bl = randBands(); br = randBands(); pt = randPots(); vl = 12'hC35;
        expL = modelChannel(bl, pt, vl);
        expR = modelChannel(br, pt, vl);
        applyStimulus(bl, br, pt, vl);
        repeat (4) @(posedge clk);
        #1;
        bus.band_lft = randBands(); bus.band_rght = randBands(); bus.pots = randPots(); bus.VOLUME = 12'h123;
        bus.strt = 1'b1;
        @(posedge clk);
        #1;
        bus.strt = 1'b0;
        checkOutput("ovrSet", 32'(bus.ovr), 32'd1);
        bus.clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_ovr = 1'b0;
        checkOutput("ovrCleared", 32'(bus.ovr), 32'd0);
        bus.strt = 1'b1;
        bus.clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        bus.strt = 1'b0;
        bus.clr_ovr = 1'b0;
        checkOutput("clrWins", 32'(bus.ovr), 32'd0);
        waitForValid(lat, gotL, gotR);
        checkOutput("ovrFirstLft",  32'(gotL), 32'(expL));
        checkOutput("ovrFirstRght", 32'(gotR), 32'(expR));

        $display("[TB] strt on vld_out cycle");
        applyStimulus(randBands(), randBands(), randPots(), 12'h800);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.vld_out === 1'b1) begin
                lat = n;
                break;
            end
        end
        checkOutput("vldCycleLat", lat, 32'd20);
        bus.strt = 1'b1;
        @(posedge clk);
        #1;
        bus.strt = 1'b0;
        checkOutput("vldCycleOvr",  32'(bus.ovr), 32'd1);
        checkOutput("vldCycleIdle", 32'(bus.busy), 32'd0);
        countValid(25, seen);
        checkOutput("vldCycleNoRun", seen, 32'd0);
        bus.clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_ovr = 1'b0;

        $display("[TB] input latching");
        bl = randBands(); br = randBands(); pt = randPots(); vl = 12'hABC;
        expL = modelChannel(bl, pt, vl);
        expR = modelChannel(br, pt, vl);
        applyStimulus(bl, br, pt, vl);
        bl2 = randBands(); br2 = randBands(); pt2 = randPots();
        bus.VOLUME = 12'h000;
        bus.band_lft = bl2; bus.band_rght = br2; bus.pots = pt2;
        waitForValid(lat, gotL, gotR);
        checkOutput("latchLft",  32'(gotL), 32'(expL));
        checkOutput("latchRght", 32'(gotR), 32'(expR));
        applyStimulus(bl2, br2, {5{12'hFFF}}, 12'h000);
        waitForValid(lat, gotL, gotR);
        checkOutput("volZeroLft",  32'(gotL), 32'd0);
        checkOutput("volZeroRght", 32'(gotR), 32'd0);

        $display("[TB] reset mid-operation");
        bl = {5{16'h7000}}; br = {5{16'h9000}}; pt = {5{12'hA00}};
        applyStimulus(bl, br, pt, 12'hFFF);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstVld",  32'(bus.vld_out), 32'd0);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstLft",  32'(bus.aud_out_lft), 32'd0);
        checkOutput("midRstRght", 32'(bus.aud_out_rght), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countValid(30, seen);
        checkOutput("midRstNoVld", seen, 32'd0);
        bl = randBands(); br = randBands(); pt = randPots(); vl = 12'h9F1;
        expL = modelChannel(bl, pt, vl);
        expR = modelChannel(br, pt, vl);
        applyStimulus(bl, br, pt, vl);
        waitForValid(lat, gotL, gotR);
        checkOutput("postRstLat",  lat, 32'd20);
        checkOutput("postRstLft",  32'(gotL), 32'(expL));
        checkOutput("postRstRght", 32'(gotR), 32'(expR));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
